mat_stream_host: RTL and testbench

MAT_STREAM_HOST -- requirements
Module: mat_stream_host

---
 rtl/mat_pkg.sv | 23 ++
 rtl/mat_stream_host_if.sv | 37 +++
 rtl/elem_ram.sv | 44 ++++
 rtl/mat_stream_host.sv | 180 ++++++++++++++++++
 tb/tb_mat_stream_host.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mat_pkg.sv
// +--------------------------------------------------------------------------+
// | mat_pkg : shared state encoding and default sizing for mat_stream_host    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package mat_pkg;

  localparam int MAT_DIM_LOG    = 1;
  localparam int MAT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_START  = 3'd3,
    ST_RECV   = 3'd4,
    ST_DONE   = 3'd5
  } mat_state_t;

endpackage

`default_nettype wire

// File: rtl/mat_stream_host_if.sv
// +--------------------------------------------------------------------------+
// | mat_stream_host_if : AXI-Stream channel between host and accelerator      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mat_stream_host_if
  import mat_pkg::*;
#(
  parameter int DATA_WIDTH = MAT_DATA_WIDTH
);

  logic                      tvalid;
  logic                      tready;
  logic [DATA_WIDTH-1:0]     tdata;
  logic [DATA_WIDTH/8-1:0]   tstrb;
  logic                      tlast;

  modport master (
    output tvalid,
    output tdata,
    output tstrb,
    output tlast,
    input  tready
  );

  // The result channel carries no strobe, so the sink side does not see it.
  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

`default_nettype wire

// File: rtl/elem_ram.sv
// +--------------------------------------------------------------------------+
// | elem_ram : one-write-port element buffer with a registered read port      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module elem_ram #(
  parameter int DEPTH_LOG  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [DEPTH_LOG-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DEPTH_LOG-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int C_DEPTH = 2**DEPTH_LOG;

  logic [DATA_WIDTH-1:0] r_mem [0:C_DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mat_stream_host.sv
// +--------------------------------------------------------------------------+
// | mat_stream_host : streams operand matrices A,B out, collects result back  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module mat_stream_host
  import mat_pkg::*;
#(
  parameter int DIM_LOG    = MAT_DIM_LOG,
  parameter int DIM        = 2**DIM_LOG,
  parameter int SIZE       = DIM*DIM,
  parameter int SIZE_LOG   = 2*DIM_LOG,
  parameter int DATA_WIDTH = MAT_DATA_WIDTH
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [SIZE_LOG-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [SIZE_LOG-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  mat_stream_host_if.master     m00_axis,
  mat_stream_host_if.slave      s00_axis,
  output logic                  sel,
  output logic                  start
);

  localparam logic [SIZE_LOG-1:0] C_LAST_IDX = SIZE_LOG'(SIZE - 1);
  localparam logic [SIZE_LOG-1:0] C_ONE      = SIZE_LOG'(1);

  mat_state_t            r_state;
  mat_state_t            w_state_nxt;
  logic [SIZE_LOG-1:0]   r_cnt;
  logic [SIZE_LOG-1:0]   w_cnt_nxt;
  logic                  r_err;
  logic                  w_err_nxt;

  logic [SIZE_LOG-1:0]   w_op_raddr;
  logic                  w_wr_a;
  logic                  w_wr_b;
  logic                  w_res_we;
  logic [DATA_WIDTH-1:0] w_a_rdata;
  logic [DATA_WIDTH-1:0] w_b_rdata;
  logic                  w_sending;

  // Operand buffers only accept host writes while the engine is idle.
  assign w_wr_a = wr_en && !wr_sel && (r_state == ST_IDLE);
  assign w_wr_b = wr_en &&  wr_sel && (r_state == ST_IDLE);

  elem_ram #(
    .DEPTH_LOG  (SIZE_LOG),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf_a (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .i_we    (w_wr_a),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (w_op_raddr),
    .o_rdata (w_a_rdata)
  );

  elem_ram #(
    .DEPTH_LOG  (SIZE_LOG),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf_b (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .i_we    (w_wr_b),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (w_op_raddr),
    .o_rdata (w_b_rdata)
  );

  elem_ram #(
    .DEPTH_LOG  (SIZE_LOG),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf_res (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .i_we    (w_res_we),
    .i_waddr (r_cnt),
    .i_wdata (s00_axis.tdata),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // The operand read address always points at the element to be presented
  // next cycle, so the registered read data lines up with tvalid and holds
  // still while the beat is stalled.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_op_raddr  = '0;
    w_res_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_state_nxt = ST_SEND_A;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      ST_SEND_A, ST_SEND_B: begin
        w_op_raddr = r_cnt;
        if (m00_axis.tready) begin
          w_cnt_nxt  = r_cnt + C_ONE;
          w_op_raddr = r_cnt + C_ONE;
          if (r_cnt == C_LAST_IDX) begin
            w_state_nxt = (r_state == ST_SEND_A) ? ST_SEND_B : ST_START;
          end
        end
      end
      ST_START: begin
        w_state_nxt = ST_RECV;
        w_cnt_nxt   = '0;
      end
      ST_RECV: begin
        if (s00_axis.tvalid) begin
          w_res_we = 1'b1;
          if (s00_axis.tlast != (r_cnt == C_LAST_IDX)) begin
            w_err_nxt = 1'b1;
          end
          if (s00_axis.tlast || (r_cnt == C_LAST_IDX)) begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_sending = (r_state == ST_SEND_A) || (r_state == ST_SEND_B);

  always_comb begin
    m00_axis.tvalid = w_sending;
    m00_axis.tlast  = w_sending && (r_cnt == C_LAST_IDX);
    m00_axis.tdata  = (r_state == ST_SEND_B) ? w_b_rdata : w_a_rdata;
    m00_axis.tstrb  = '1;
    s00_axis.tready = (r_state == ST_RECV);
    sel             = (r_state == ST_SEND_B);
    start           = (r_state == ST_START);
    done            = (r_state == ST_DONE);
    busy            = (r_state != ST_IDLE);
    err             = r_err;
  end

endmodule

`default_nettype wire

// File: tb/tb_mat_stream_host.sv
// +--------------------------------------------------------------------------+
// | tb_mat_stream_host : directed self-checking bench for mat_stream_host     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mat_stream_host;

  localparam int DW = 32;

  logic          s00_axi_aclk = 1'b0;
  logic          s00_axi_aresetn;
  logic          wr_en;
  logic          wr_sel;
  logic [1:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          go;
  logic          busy;
  logic          done;
  logic          err;
  logic          sel;
  logic          start;

  mat_stream_host_if #(.DATA_WIDTH(DW)) m00_axis ();
  mat_stream_host_if #(.DATA_WIDTH(DW)) s00_axis ();

  mat_stream_host dut (
    .s00_axi_aclk    (s00_axi_aclk),
    .s00_axi_aresetn (s00_axi_aresetn),
    .wr_en           (wr_en),
    .wr_sel          (wr_sel),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .go              (go),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .m00_axis        (m00_axis),
    .s00_axis        (s00_axis),
    .sel             (sel),
    .start           (start)
  );

  always #5 s00_axi_aclk = ~s00_axi_aclk;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] cap_data [16];
  logic          cap_last [16];
  logic          cap_sel  [16];
  int            cap_n;
  int            start_cnt;
  int            done_cnt;
  int            extra_tx;
  logic          err_at_done;
  logic [DW-1:0] resp [4];
  logic [3:0]    bp_pat = 4'b1001;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic s, input logic [1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = s; wr_addr = a; wr_data = d;
    @(negedge s00_axi_aclk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [DW-1:0] exp);
    rd_addr = a;
    @(negedge s00_axi_aclk);
    chk($sformatf("rd_data[%0d]", a), rd_data, exp);
  endtask

  // A = {1,2,3,4}, B = {5,6,7,8}: the stream must be 1..8 with tlast on 4 and 8.
  task automatic check_tx();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_data[%0d]", i), cap_data[i], DW'(i + 1));
      chk($sformatf("tx_last[%0d]", i), DW'(cap_last[i]), DW'((i == 3) || (i == 7)));
      chk($sformatf("tx_sel[%0d]", i), DW'(cap_sel[i]), DW'(i >= 4));
    end
  endtask

  task automatic run_op(input bit bp, input int last_at, input bit poke);
    int            cyc;
    int            rbeat;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    cap_n = 0; start_cnt = 0; done_cnt = 0; extra_tx = 0;
    go = 1'b1;
    @(negedge s00_axi_aclk);
    go = 1'b0;
    chk("tvalid_after_go", DW'(m00_axis.tvalid), 1);
    chk("tstrb_ones", DW'(m00_axis.tstrb), 32'hF);
    cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (cap_n < 8 && cyc < 200) begin
      m00_axis.tready = bp ? bp_pat[cyc % 4] : 1'b1;
      if (poke && cyc == 1) begin
        go = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 32'd99;
      end else if (poke && cyc == 2) begin
        go = 1'b0; wr_en = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_tvalid", DW'(m00_axis.tvalid), 1);
        chk("stall_tdata", m00_axis.tdata, prev_data);
      end
      if (m00_axis.tvalid && m00_axis.tready) begin
        cap_data[cap_n] = m00_axis.tdata;
        cap_last[cap_n] = m00_axis.tlast;
        cap_sel[cap_n]  = sel;
        cap_n++;
      end
      prev_stall = m00_axis.tvalid && !m00_axis.tready;
      prev_data  = m00_axis.tdata;
      @(negedge s00_axi_aclk);
      cyc++;
    end
    go = 1'b0; wr_en = 1'b0;
    m00_axis.tready = 1'b1;
    chk("tx_beats", DW'(cap_n), 8);
    rbeat = 0; cyc = 0;
    while (!done && cyc < 100) begin
      if (start) start_cnt++;
      if (m00_axis.tvalid) extra_tx++;
      if (s00_axis.tready && rbeat < 4) begin
        s00_axis.tvalid = 1'b1;
        s00_axis.tdata  = resp[rbeat];
        s00_axis.tlast  = (rbeat == last_at);
        rbeat++;
      end else begin
        s00_axis.tvalid = 1'b0;
        s00_axis.tlast  = 1'b0;
      end
      @(negedge s00_axi_aclk);
      cyc++;
    end
    s00_axis.tvalid = 1'b0;
    s00_axis.tlast  = 1'b0;
    if (done) done_cnt = 1;
    err_at_done = err;
    chk("done_pulse", DW'(done_cnt), 1);
    chk("start_once", DW'(start_cnt), 1);
    chk("no_extra_tx", DW'(extra_tx), 0);
    @(negedge s00_axi_aclk);
    chk("done_single", DW'(done), 0);
    chk("idle_after", DW'(busy), 0);
  endtask

  initial begin
    int cyc;
    s00_axi_aresetn = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; go = 1'b0;
    m00_axis.tready = 1'b0;
    s00_axis.tvalid = 1'b0; s00_axis.tdata = '0; s00_axis.tlast = 1'b0;
    @(negedge s00_axi_aclk);
    @(negedge s00_axi_aclk);
    chk("rst_tvalid", DW'(m00_axis.tvalid), 0);
    chk("rst_tlast",  DW'(m00_axis.tlast), 0);
    chk("rst_s_tready", DW'(s00_axis.tready), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_done_start_err_sel", DW'({done, start, err, sel}), 0);
    chk("rst_rd_data", rd_data, 0);
    s00_axi_aresetn = 1'b1;
    @(negedge s00_axi_aclk);

    wr(1'b0, 2'd0, 32'd1); wr(1'b0, 2'd1, 32'd2); wr(1'b0, 2'd2, 32'd3); wr(1'b0, 2'd3, 32'd4);
    wr(1'b1, 2'd0, 32'd5); wr(1'b1, 2'd1, 32'd6); wr(1'b1, 2'd2, 32'd7); wr(1'b1, 2'd3, 32'd8);

    // Normal run: [[1,2],[3,4]] x [[5,6],[7,8]] = [[19,22],[43,50]].
    resp[0] = 32'd19; resp[1] = 32'd22; resp[2] = 32'd43; resp[3] = 32'd50;
    run_op(1'b0, 3, 1'b0);
    check_tx();
    chk("normal_err", DW'(err_at_done), 0);
    rd_chk(2'd0, 32'd19); rd_chk(2'd1, 32'd22); rd_chk(2'd2, 32'd43); rd_chk(2'd3, 32'd50);

    // Backpressure with tready 1,0,0,1.
    resp[0] = 32'd9; resp[1] = 32'd10; resp[2] = 32'd11; resp[3] = 32'd12;
    run_op(1'b1, 3, 1'b0);
    check_tx();
    chk("bp_err", DW'(err_at_done), 0);
    rd_chk(2'd0, 32'd9); rd_chk(2'd3, 32'd12);

    // Early tlast on beat 2: indices 2,3 keep the previous run's results.
    resp[0] = 32'd100; resp[1] = 32'd101; resp[2] = 32'd102; resp[3] = 32'd103;
    run_op(1'b0, 1, 1'b0);
    chk("early_err", DW'(err_at_done), 1);
    chk("err_sticky", DW'(err), 1);
    rd_chk(2'd1, 32'd101); rd_chk(2'd2, 32'd11);

    // go and wr_en while busy are ignored; the accepted go clears err.
    resp[0] = 32'd19; resp[1] = 32'd22; resp[2] = 32'd43; resp[3] = 32'd50;
    run_op(1'b0, 3, 1'b1);
    check_tx();
    chk("poke_err_cleared", DW'(err_at_done), 0);

    // Reset in the middle of SEND_B beat 2.
    rd_addr = 2'd0;
    go = 1'b1;
    @(negedge s00_axi_aclk);
    go = 1'b0;
    m00_axis.tready = 1'b1;
    cyc = 0;
    while (!(m00_axis.tvalid && sel && m00_axis.tdata == 32'd6) && cyc < 50) begin
      @(negedge s00_axi_aclk);
      cyc++;
    end
    chk("rst_reach_b1", m00_axis.tdata, 32'd6);
    chk("rd_pre_rst", rd_data, 32'd19);
    s00_axi_aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", DW'(m00_axis.tvalid), 0);
    chk("mid_rst_tlast", DW'(m00_axis.tlast), 0);
    chk("mid_rst_sel_busy", DW'({sel, busy}), 0);
    chk("mid_rst_start_done_err", DW'({start, done, err, s00_axis.tready}), 0);
    chk("mid_rst_rd_data", rd_data, 0);
    @(negedge s00_axi_aclk);
    s00_axi_aresetn = 1'b1;
    @(negedge s00_axi_aclk);
    rd_chk(2'd1, 32'd22);
    run_op(1'b0, 3, 1'b0);
    check_tx();
    chk("post_rst_err", DW'(err_at_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
